lmsm_sequencer: RTL and testbench
=================================

// Module: lmsm_sequencer
// PURPOSE
//  Micro-sequencer for Load-Multiple (LM) / Store-Multiple (SM) instructions.
//  Takes one LM/SM IR plus its base-register value and expands it into one
//  single-register memory micro-op per set mask bit. These micro-ops drive the
//  MEM address path and the writeback register port / store-data read port.
//  While expanding, it stalls the upstream pipeline.
// PARAMETERS
//  ADDR_W     16       width of base value and memory address
//  ADDR_STEP  1        address increment between consecutive micro-ops
//  LM_OPCODE  4'b0110  IR[15:12] value for LM
//  SM_OPCODE  4'b0111  IR[15:12] value for SM
// PORTS
//  clk           in   1       clock; all state updates on rising edge
//  rst           in   1       asynchronous reset, active-high
//  valid_in      in   1       IR_in/base_val carry a valid instruction
//  IR_in         in   16      instruction; mask = IR_in[7:0], bit i -> Ri
//  base_val      in   ADDR_W  value of base register IR_in[11:9]
//  flush         in   1       synchronous abort (branch mispredict)
//  uop_ready     in   1       downstream accepts current micro-op
//  stall_out     out  1       freeze IF/ID/RR while high
//  uop_valid     out  1       micro-op outputs are valid
//  uop_is_load   out  1       1 = LM micro-op, 0 = SM micro-op
//  uop_mem_addr  out  ADDR_W  memory address of current micro-op
//  uop_reg_add   out  3       LM: dest register; SM: store-data source reg
//  uop_reg_wr_en out  1       = uop_valid & uop_is_load
//  uop_mem_wr_en out  1       = uop_valid & ~uop_is_load
//  uop_cnt       out  4       micro-ops accepted so far in current instr
//  done          out  1       one-cycle pulse: instruction fully expanded
// BEHAVIOUR
//  FSM states: IDLE, RUN, DONE.
//  - Reset (async, rst=1): state=IDLE. Remaining mask, addr reg, type and
//    uop_cnt are cleared. All outputs are 0.
//  - start = valid_in & state==IDLE & IR_in[15:12] in {LM_OPCODE, SM_OPCODE}.
//    valid_in is ignored outside IDLE.
//  - IDLE, start: latch rem_mask=IR_in[7:0], addr=base_val,
//    is_load=(opcode==LM_OPCODE), uop_cnt=0.
//    Go to RUN if mask!=0; go to DONE if mask==0 (no micro-ops issued).
//  - RUN: uop_valid=1.
//    uop_reg_add = index of the lowest set bit of rem_mask.
//    uop_mem_addr = addr.
//    On uop_valid & uop_ready: clear that bit, addr += ADDR_STEP
//    (mod 2^ADDR_W, wraps silently), uop_cnt += 1.
//    If the cleared bit was the last set bit, go to DONE.
//    If uop_ready=0, all uop_* outputs hold unchanged.
//  - DONE: done=1 for exactly one cycle, uop_valid=0; then go to IDLE.
//  - stall_out = start | (state==RUN). It is low in DONE, so the next
//    instruction advances in the same cycle that done pulses.
//  - Micro-op outputs are combinational from registered state only. There is
//    no combinational path from uop_ready to uop_* outputs.
//  - Latency: first micro-op appears 1 cycle after start. An N-bit mask with
//    uop_ready=1 takes N RUN cycles, then 1 DONE cycle.
//  - flush (highest priority after rst): next state=IDLE, rem_mask=0,
//    uop_cnt=0. No done pulse. A micro-op presented in the flush cycle is
//    still accepted downstream if uop_ready=1; it is not re-issued.
//  - Flag writes are not made by micro-ops. Only the writeback stage's own
//    flag logic acts, and only on the original instruction.
// TESTING
//  1 LM, IR=16'h6285 (Ra=R1, mask 8'h85), base_val=16'h0100, ready=1 ->
//    (R0,0x0100),(R2,0x0101),(R7,0x0102) on 3 cycles, reg_wr_en=1,
//    mem_wr_en=0; done on the 4th cycle; uop_cnt=3; stall_out low at done.
//  2 SM, mask 8'hFF, base 16'hFFFE -> addresses FFFE,FFFF,0000..0005 (wrap),
//    regs R0..R7, mem_wr_en=1 each cycle, done after 8 uops.
//  3 LM, mask 8'h03, uop_ready low for 3 cycles on first uop -> R0/0x0100 held
//    stable 3 cycles, stall_out stays 1; R1/0x0101 follows after ready rises.
//  4 LM, mask 8'h00 -> no uop_valid; done pulses 1 cycle after start;
//    stall_out high only in start cycle.
//  5 SM, mask 8'h0F, flush in 2nd RUN cycle -> IDLE next cycle, no done,
//    uop_cnt=0; a new LM in the following cycle starts normally.
//  6 rst asserted mid-RUN (async, off clock edge) -> all outputs 0
//    immediately; after release, valid_in with a non-LM/SM opcode
//    (IR=16'h1000) -> no stall, no uop.

Source files
------------

// File: rtl/lmsm_sequencer_if.sv
// Handshake bundle between the pipeline and the LM/SM micro-sequencer.
// Latency: n/a (wires only).
// Backpressure: uop_ready from the MEM stage, stall_out back to IF/ID/RR.
//   master : pipeline side, drives the instruction, flush and uop_ready
//   slave  : sequencer side, drives the stall, micro-op and done signals
interface lmsm_sequencer_if #(
    parameter int ADDR_W = 16
);
    logic              valid_in;
    logic [15:0]       IR_in;
    logic [ADDR_W-1:0] base_val;
    logic              flush;
    logic              uop_ready;
    logic              stall_out;
    logic              uop_valid;
    logic              uop_is_load;
    logic [ADDR_W-1:0] uop_mem_addr;
    logic [2:0]        uop_reg_add;
    logic              uop_reg_wr_en;
    logic              uop_mem_wr_en;
    logic [3:0]        uop_cnt;
    logic              done;

    modport master (
        output valid_in, IR_in, base_val, flush, uop_ready,
        input  stall_out, uop_valid, uop_is_load, uop_mem_addr, uop_reg_add,
               uop_reg_wr_en, uop_mem_wr_en, uop_cnt, done
    );

    modport slave (
        input  valid_in, IR_in, base_val, flush, uop_ready,
        output stall_out, uop_valid, uop_is_load, uop_mem_addr, uop_reg_add,
               uop_reg_wr_en, uop_mem_wr_en, uop_cnt, done
    );
endinterface

// File: rtl/lmsm_sequencer.sv
// Expands one LM/SM instruction into one memory micro-op per set mask bit.
// Latency: first micro-op 1 cycle after start; N uops in N cycles, then 1 done cycle.
// Backpressure: uop_ready=0 holds the current micro-op; stall_out freezes upstream.
//   clk, rst : clock and asynchronous active-high reset
//   bus      : slave modport; instruction in, micro-op / stall / done out
module lmsm_sequencer #(
    parameter int         ADDR_W    = 16,
    parameter int         ADDR_STEP = 1,
    parameter logic [3:0] LM_OPCODE = 4'b0110,
    parameter logic [3:0] SM_OPCODE = 4'b0111
) (
    input  logic               clk,
    input  logic               rst,
    lmsm_sequencer_if.slave    bus
);
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t            r_state;
    logic [7:0]        r_rem_mask;
    logic [ADDR_W-1:0] r_addr;
    logic              r_is_load;
    logic [3:0]        r_cnt;

    logic [3:0]        w_opcode;
    logic              w_is_lmsm;
    logic              w_start;
    logic              w_run;
    logic [7:0]        w_low_bit;
    logic [7:0]        w_mask_next;
    logic [2:0]        w_low_idx;
    logic [3:0]        w_unused_ir;

    assign w_opcode  = bus.IR_in[15:12];
    assign w_is_lmsm = (w_opcode == LM_OPCODE) || (w_opcode == SM_OPCODE);
    // New instructions are only looked at while idle.
    assign w_start   = bus.valid_in && (r_state == S_IDLE) && w_is_lmsm;
    assign w_run     = (r_state == S_RUN);

    // Base register field and bit 8 are resolved upstream; only opcode and mask matter here.
    assign w_unused_ir = bus.IR_in[11:8];

    // Isolate the lowest set bit (two's-complement trick) and the mask left after it.
    assign w_low_bit   = r_rem_mask & 8'(~r_rem_mask + 8'd1);
    assign w_mask_next = r_rem_mask & ~w_low_bit;

    always_comb begin
        w_low_idx = 3'd0;
        for (int i = 7; i >= 0; i--) begin
            if (r_rem_mask[i]) begin
                w_low_idx = 3'(i);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_rem_mask <= 8'd0;
            r_addr     <= '0;
            r_is_load  <= 1'b0;
            r_cnt      <= 4'd0;
        end else if (bus.flush) begin
            // Abort without a done pulse; a uop accepted this cycle is not re-issued.
            r_state    <= S_IDLE;
            r_rem_mask <= 8'd0;
            r_cnt      <= 4'd0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_start) begin
                        r_rem_mask <= bus.IR_in[7:0];
                        r_addr     <= bus.base_val;
                        r_is_load  <= (w_opcode == LM_OPCODE);
                        r_cnt      <= 4'd0;
                        // An empty mask issues nothing and goes straight to done.
                        r_state    <= (bus.IR_in[7:0] != 8'd0) ? S_RUN : S_DONE;
                    end
                end
                S_RUN: begin
                    if (bus.uop_ready) begin
                        r_rem_mask <= w_mask_next;
                        r_addr     <= r_addr + ADDR_W'(ADDR_STEP);
                        r_cnt      <= r_cnt + 4'd1;
                        if (w_mask_next == 8'd0) begin
                            r_state <= S_DONE;
                        end
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    // Micro-op outputs depend only on registered state; uop_ready never reaches them.
    assign bus.uop_valid     = w_run;
    assign bus.uop_is_load   = w_run & r_is_load;
    assign bus.uop_mem_addr  = w_run ? r_addr : '0;
    assign bus.uop_reg_add   = w_run ? w_low_idx : 3'd0;
    assign bus.uop_reg_wr_en = w_run & r_is_load;
    assign bus.uop_mem_wr_en = w_run & ~r_is_load;
    assign bus.uop_cnt       = r_cnt;
    assign bus.done          = (r_state == S_DONE);
    // Low in DONE so the next instruction can advance while done pulses.
    assign bus.stall_out     = w_start | w_run;
endmodule

// File: tb/tb_lmsm_sequencer.sv
module tb_lmsm_sequencer;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   errors = 0;
    int   checks = 0;

    always #5 clk = ~clk;

    lmsm_sequencer_if #(.ADDR_W(16)) bus ();

    lmsm_sequencer dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // ---------------- reference model: queue of pending micro-ops ----------------
    logic [2:0]  mq_reg[$];
    logic [15:0] mq_addr[$];
    bit          m_done;
    int          m_cnt;
    bit          m_is_load;

    function automatic bit m_start();
        return bus.valid_in && (mq_reg.size() == 0) && !m_done &&
               (bus.IR_in[15:12] == 4'h6 || bus.IR_in[15:12] == 4'h7);
    endfunction

    task automatic model_reset();
        mq_reg.delete();
        mq_addr.delete();
        m_done = 0;
        m_cnt  = 0;
        m_is_load = 0;
    endtask

    // Called just after each rising edge with the inputs that were sampled.
    task automatic model_clock();
        bit st;
        int k;
        st = m_start();
        if (rst) begin
            model_reset();
        end else if (bus.flush) begin
            mq_reg.delete();
            mq_addr.delete();
            m_done = 0;
            m_cnt  = 0;
        end else if (m_done) begin
            m_done = 0;
        end else if (mq_reg.size() != 0) begin
            if (bus.uop_ready) begin
                void'(mq_reg.pop_front());
                void'(mq_addr.pop_front());
                m_cnt++;
                if (mq_reg.size() == 0) m_done = 1;
            end
        end else if (st) begin
            m_is_load = (bus.IR_in[15:12] == 4'h6);
            m_cnt = 0;
            k = 0;
            for (int i = 0; i < 8; i++) begin
                if (bus.IR_in[i]) begin
                    mq_reg.push_back(3'(i));
                    mq_addr.push_back(16'(bus.base_val + 16'(k)));
                    k++;
                end
            end
            if (mq_reg.size() == 0) m_done = 1;
        end
    endtask

    // ---------------- checking helpers ----------------
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_model(input string tag);
        bit v;
        v = (mq_reg.size() != 0);
        chk({tag, ".stall"}, 32'(bus.stall_out), 32'(m_start() || v));
        chk({tag, ".valid"}, 32'(bus.uop_valid), 32'(v));
        chk({tag, ".done"},  32'(bus.done), 32'(m_done));
        chk({tag, ".cnt"},   32'(bus.uop_cnt), 32'(m_cnt));
        chk({tag, ".reg_wr"}, 32'(bus.uop_reg_wr_en), 32'(v && m_is_load));
        chk({tag, ".mem_wr"}, 32'(bus.uop_mem_wr_en), 32'(v && !m_is_load));
        if (v) begin
            chk({tag, ".addr"}, 32'(bus.uop_mem_addr), 32'(mq_addr[0]));
            chk({tag, ".reg"},  32'(bus.uop_reg_add), 32'(mq_reg[0]));
            chk({tag, ".load"}, 32'(bus.uop_is_load), 32'(m_is_load));
        end
    endtask

    task automatic apply(input logic vin, input logic [15:0] ir, input logic [15:0] base,
                         input logic fl, input logic rdy);
        @(negedge clk);
        bus.valid_in  = vin;
        bus.IR_in     = ir;
        bus.base_val  = base;
        bus.flush     = fl;
        bus.uop_ready = rdy;
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        model_clock();
    endtask

    task automatic run_model(input string tag, input logic vin, input logic [15:0] ir,
                             input logic [15:0] base, input logic fl, input logic rdy);
        apply(vin, ir, base, fl, rdy);
        check_model(tag);
        tick();
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, ".stall"},  32'(bus.stall_out), 0);
        chk({tag, ".valid"},  32'(bus.uop_valid), 0);
        chk({tag, ".load"},   32'(bus.uop_is_load), 0);
        chk({tag, ".addr"},   32'(bus.uop_mem_addr), 0);
        chk({tag, ".reg"},    32'(bus.uop_reg_add), 0);
        chk({tag, ".reg_wr"}, 32'(bus.uop_reg_wr_en), 0);
        chk({tag, ".mem_wr"}, 32'(bus.uop_mem_wr_en), 0);
        chk({tag, ".cnt"},    32'(bus.uop_cnt), 0);
        chk({tag, ".done"},   32'(bus.done), 0);
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        logic        vin;
        logic [15:0] ir;
        logic [15:0] base;
        logic        fl;
        logic        rdy;
        logic        e_stall;
        logic        e_valid;
        logic        e_load;
        logic [15:0] e_addr;
        logic [2:0]  e_reg;
        logic [3:0]  e_cnt;
        logic        e_done;
    } vec_t;

    vec_t vt[9];

    initial begin
        // LM R1 mask 85 from 0x0100, then LM with empty mask
        vt[0] = '{1'b1, 16'h6285, 16'h0100, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 16'h0000, 3'd0, 4'd0, 1'b0};
        vt[1] = '{1'b0, 16'h0000, 16'h0000, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 16'h0100, 3'd0, 4'd0, 1'b0};
        vt[2] = '{1'b1, 16'h7001, 16'h0000, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 16'h0101, 3'd2, 4'd1, 1'b0};
        vt[3] = '{1'b0, 16'h0000, 16'h0000, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 16'h0102, 3'd7, 4'd2, 1'b0};
        vt[4] = '{1'b0, 16'h0000, 16'h0000, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0000, 3'd0, 4'd3, 1'b1};
        vt[5] = '{1'b1, 16'h1000, 16'h0000, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0000, 3'd0, 4'd3, 1'b0};
        vt[6] = '{1'b1, 16'h6000, 16'h0000, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 16'h0000, 3'd0, 4'd3, 1'b0};
        vt[7] = '{1'b0, 16'h0000, 16'h0000, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0000, 3'd0, 4'd0, 1'b1};
        vt[8] = '{1'b0, 16'h0000, 16'h0000, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0000, 3'd0, 4'd0, 1'b0};

        bus.valid_in = 0; bus.IR_in = 0; bus.base_val = 0; bus.flush = 0; bus.uop_ready = 0;
        model_reset();
        #3;
        check_all_zero("reset");
        @(negedge clk);
        rst = 1'b0;

        // -------- table-driven vectors --------
        foreach (vt[i]) begin
            string tag;
            tag = $sformatf("vec%0d", i);
            apply(vt[i].vin, vt[i].ir, vt[i].base, vt[i].fl, vt[i].rdy);
            chk({tag, ".stall"},  32'(bus.stall_out), 32'(vt[i].e_stall));
            chk({tag, ".valid"},  32'(bus.uop_valid), 32'(vt[i].e_valid));
            chk({tag, ".done"},   32'(bus.done), 32'(vt[i].e_done));
            chk({tag, ".cnt"},    32'(bus.uop_cnt), 32'(vt[i].e_cnt));
            chk({tag, ".reg_wr"}, 32'(bus.uop_reg_wr_en), 32'(vt[i].e_valid & vt[i].e_load));
            chk({tag, ".mem_wr"}, 32'(bus.uop_mem_wr_en), 32'(vt[i].e_valid & ~vt[i].e_load));
            if (vt[i].e_valid) begin
                chk({tag, ".addr"}, 32'(bus.uop_mem_addr), 32'(vt[i].e_addr));
                chk({tag, ".reg"},  32'(bus.uop_reg_add), 32'(vt[i].e_reg));
                chk({tag, ".load"}, 32'(bus.uop_is_load), 32'(vt[i].e_load));
            end
            tick();
        end

        // -------- SM mask FF from 0xFFFE: address wraps --------
        run_model("sm_wrap_start", 1'b1, 16'h72FF, 16'hFFFE, 1'b0, 1'b1);
        for (int c = 0; c < 10; c++) begin
            if (c == 2) chk("sm_wrap.addr0000", 32'(bus.uop_mem_addr), 32'h0000);
            if (c == 8) chk("sm_wrap.done", 32'(bus.done), 1);
            run_model("sm_wrap", 1'b0, 16'h0, 16'h0, 1'b0, 1'b1);
        end
        chk("sm_wrap.cnt", 32'(bus.uop_cnt), 8);

        // -------- LM mask 03, downstream not ready for 3 cycles --------
        run_model("bp_start", 1'b1, 16'h6203, 16'h0100, 1'b0, 1'b1);
        for (int c = 0; c < 3; c++) begin
            apply(1'b0, 16'h0, 16'h0, 1'b0, 1'b0);
            check_model("bp_hold");
            chk("bp_hold.addr", 32'(bus.uop_mem_addr), 32'h0100);
            tick();
        end
        for (int c = 0; c < 4; c++) run_model("bp_go", 1'b0, 16'h0, 16'h0, 1'b0, 1'b1);

        // -------- SM mask 0F, flush on 2nd RUN cycle, then a fresh LM --------
        run_model("fl_start", 1'b1, 16'h720F, 16'h0200, 1'b0, 1'b1);
        run_model("fl_run1", 1'b0, 16'h0, 16'h0, 1'b0, 1'b1);
        run_model("fl_flush", 1'b0, 16'h0, 16'h0, 1'b1, 1'b1);
        apply(1'b1, 16'h6281, 16'h0300, 1'b0, 1'b1);
        check_model("fl_after");
        chk("fl_after.cnt", 32'(bus.uop_cnt), 0);
        chk("fl_after.done", 32'(bus.done), 0);
        chk("fl_after.stall", 32'(bus.stall_out), 1);
        tick();
        for (int c = 0; c < 4; c++) run_model("fl_lm", 1'b0, 16'h0, 16'h0, 1'b0, 1'b1);

        // -------- async reset mid-RUN, then a non-LM/SM opcode --------
        run_model("ar_start", 1'b1, 16'h72F0, 16'h0400, 1'b0, 1'b1);
        run_model("ar_run", 1'b0, 16'h0, 16'h0, 1'b0, 1'b1);
        @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        check_all_zero("async_rst");
        model_reset();
        @(negedge clk);
        rst = 1'b0;
        run_model("nop_op", 1'b1, 16'h1000, 16'h0000, 1'b0, 1'b1);
        chk("nop_op.valid", 32'(bus.uop_valid), 0);
        run_model("nop_op2", 1'b0, 16'h0, 16'h0, 1'b0, 1'b1);

        // -------- randomized traffic against the model --------
        for (int c = 0; c < 400; c++) begin
            logic [3:0]  op;
            logic [7:0]  mask;
            logic [15:0] ir;
            case ($urandom_range(0, 4))
                0, 1:    op = 4'h6;
                2, 3:    op = 4'h7;
                default: op = 4'($urandom_range(0, 15));
            endcase
            mask = ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom);
            ir = {op, 4'($urandom), mask};
            run_model("rand", 1'($urandom_range(0, 1)), ir, 16'($urandom),
                      ($urandom_range(0, 19) == 0), ($urandom_range(0, 9) < 7));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
